// File: rtl/pulse_frame_packer.sv
// pulse_frame_packer: timestamps identified pulse results into a FIFO and streams them as 14-byte checksummed frames
module pulse_frame_packer #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk_96MHz,
  input  logic                     reset,
  input  logic                     data_availible,
  input  logic [16:0]              pulse_id_0,
  input  logic [16:0]              pulse_id_1,
  input  logic [16:0]              polynomial,
  input  logic [23:0]              system_timestamp,
  output logic                     reset_pulse_identifier,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               overflow_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  logic [74:0]   mem [DEPTH];
  logic [74:0]   frame_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          armed_q, ack_q;
  logic [7:0]    ovf_q;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic          cap, full, wr_en, pop, hs, fifo_ne;
  logic [7:0]    fb [16];
  assign cap     = armed_q && data_availible;
  assign full    = level_q == LW'(DEPTH);
  assign wr_en   = cap && !full;
  assign pop     = state_q == LOAD;
  assign fifo_ne = level_q != '0 || wr_en;
  assign hs      = tx_valid && tx_ready;
  assign level_d = level_q + LW'(wr_en) - LW'(pop);
  assign reset_pulse_identifier = ack_q;
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
  assign tx_valid       = state_q == SEND;
  assign tx_byte        = tx_valid ? fb[idx_q] : 8'h00;
  always_ff @(posedge clk_96MHz) begin
    if (wr_en) mem[wr_ptr_q] <= {polynomial, pulse_id_0, pulse_id_1, system_timestamp};
    if (pop) frame_q <= mem[rd_ptr_q];
  end
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      armed_q  <= 1'b1;
      ack_q    <= 1'b0;
      ovf_q    <= 8'h00;
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      chk_q    <= 8'h00;
    end else begin
      wr_ptr_q <= wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_q  <= level_d;
      armed_q  <= cap ? 1'b0 : (!data_availible ? 1'b1 : armed_q);
      ack_q    <= cap;
      ovf_q    <= (cap && full && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
      state_q  <= state_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
    end
  end
  always_comb begin
    fb     = '{default: 8'h00};
    fb[0]  = SYNC_BYTE;
    fb[1]  = {7'b0, frame_q[74]};
    fb[2]  = frame_q[73:66];
    fb[3]  = frame_q[65:58];
    fb[4]  = {7'b0, frame_q[57]};
    fb[5]  = frame_q[56:49];
    fb[6]  = frame_q[48:41];
    fb[7]  = {7'b0, frame_q[40]};
    fb[8]  = frame_q[39:32];
    fb[9]  = frame_q[31:24];
    fb[10] = frame_q[23:16];
    fb[11] = frame_q[15:8];
    fb[12] = frame_q[7:0];
    fb[13] = chk_q;
  end
  always_comb begin
    state_d = state_q == IDLE ? (fifo_ne ? LOAD : IDLE) :
              state_q == LOAD ? SEND :
              (hs && idx_q == 4'd13) ? (fifo_ne ? LOAD : IDLE) : SEND;
    idx_d   = state_q == LOAD ? 4'd0 : hs ? idx_q + 4'd1 : idx_q;
    chk_d   = state_q == LOAD ? 8'h00 :
              (hs && idx_q != 4'd0 && idx_q != 4'd13) ? chk_q ^ tx_byte : chk_q;
  end
endmodule

// File: tb/tb_pulse_frame_packer.sv
// tb_pulse_frame_packer: randomized and directed checks of the pulse frame packer against a frame-level model
module tb_pulse_frame_packer;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset = 1'b1, da = 1'b0, tx_ready = 1'b0;
  logic [16:0] poly = '0, id0 = '0, id1 = '0;
  logic [23:0] ts = '0;
  logic ack, tx_valid;
  logic [7:0] tx_byte, ovf;
  logic [2:0] lvl;
  int checks = 0, fails = 0, ack_cnt = 0, mode = 0, rx_base = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ref1 [14] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h55,
                            8'h00, 8'h00, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h8F};
  always #5 clk = ~clk;
  pulse_frame_packer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk_96MHz(clk), .reset(reset), .data_availible(da),
    .pulse_id_0(id0), .pulse_id_1(id1), .polynomial(poly), .system_timestamp(ts),
    .reset_pulse_identifier(ack), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .fifo_level(lvl), .overflow_count(ovf));
  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready) rx_q.push_back(tx_byte);
    if (ack) ack_cnt++;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
    ts = ts + 24'd1;
    if (mode == 1) tx_ready = ~tx_ready;
    else if (mode == 2) tx_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic push_exp(input logic [16:0] p, a, b, input logic [23:0] t);
    logic [7:0] f [14];
    logic [7:0] c;
    f[0] = 8'hA5;
    f[1] = {7'b0, p[16]}; f[2] = p[15:8]; f[3] = p[7:0];
    f[4] = {7'b0, a[16]}; f[5] = a[15:8]; f[6] = a[7:0];
    f[7] = {7'b0, b[16]}; f[8] = b[15:8]; f[9] = b[7:0];
    f[10] = t[23:16]; f[11] = t[15:8]; f[12] = t[7:0];
    c = 8'h00;
    for (int i = 1; i <= 12; i++) c = c ^ f[i];
    f[13] = c;
    for (int i = 0; i < 14; i++) exp_q.push_back(f[i]);
  endtask
  task automatic send(input logic [16:0] p, a, b, input bit keep);
    poly = p; id0 = a; id1 = b; da = 1'b1;
    if (keep) push_exp(p, a, b, ts);
    cyc();
    da = 1'b0;
    cyc();
    cyc();
  endtask
  task automatic wait_rx(input int n);
    for (int k = 0; k < 3000 && rx_q.size() < rx_base + n; k++) cyc();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", tx_valid); end
    checks++; if (tx_byte !== 8'h00) begin fails++; $display("FAIL reset_byte got %h want 00", tx_byte); end
    checks++; if (lvl !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", lvl); end
    checks++; if (ovf !== 8'd0) begin fails++; $display("FAIL reset_ovf got %0d want 0", ovf); end
    reset = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b want 0", tx_valid); end
  endtask
  task automatic test_frame();
    rx_base = rx_q.size();
    tx_ready = 1'b1;
    poly = 17'h10001; id0 = 17'h00055; id1 = 17'h000AA; ts = 24'h123456; da = 1'b1;
    cyc();
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL frame_ack got %b want 1", ack); end
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL frame_load_valid got %b want 0", tx_valid); end
    checks++; if (lvl !== 3'd1) begin fails++; $display("FAIL frame_load_level got %0d want 1", lvl); end
    da = 1'b0;
    cyc();
    checks++; if (ack !== 1'b0) begin fails++; $display("FAIL frame_ack_pulse got %b want 0", ack); end
    checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'hA5) begin fails++; $display("FAIL frame_sync got %b/%h want 1/a5", tx_valid, tx_byte); end
    wait_rx(14);
    repeat (4) cyc();
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== ref1[i]) begin
        fails++; $display("FAIL frame_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, ref1[i]);
      end
    end
    checks++; if (rx_q.size() != rx_base + 14) begin fails++; $display("FAIL frame_count got %0d want 14", rx_q.size() - rx_base); end
  endtask
  task automatic test_hold();
    int a0;
    exp_q.delete(); rx_base = rx_q.size(); a0 = ack_cnt;
    poly = 17'($urandom); id0 = 17'($urandom); id1 = 17'($urandom); da = 1'b1;
    push_exp(poly, id0, id1, ts);
    cyc();
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL hold_ack1 got %b want 1", ack); end
    repeat (10) cyc();
    checks++; if (ack_cnt - a0 != 1) begin fails++; $display("FAIL hold_single got %0d acks want 1", ack_cnt - a0); end
    da = 1'b0;
    cyc();
    da = 1'b1;
    push_exp(poly, id0, id1, ts);
    cyc();
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL hold_ack2 got %b want 1", ack); end
    da = 1'b0;
    cyc(); cyc();
    checks++; if (ack_cnt - a0 != 2) begin fails++; $display("FAIL hold_double got %0d acks want 2", ack_cnt - a0); end
    wait_rx(28);
    repeat (4) cyc();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== exp_q[i]) begin
        fails++; $display("FAIL hold_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, exp_q[i]);
      end
    end
  endtask
  task automatic test_overflow();
    int a0;
    exp_q.delete(); rx_base = rx_q.size(); a0 = ack_cnt;
    tx_ready = 1'b0;
    // the first result moves into the frame register straight away, so DEPTH+1 results fit
    for (int k = 0; k < DEPTH + 3; k++) send(17'($urandom), 17'($urandom), 17'($urandom), k < DEPTH + 1);
    checks++; if (lvl !== 3'(DEPTH)) begin fails++; $display("FAIL ovf_level got %0d want %0d", lvl, DEPTH); end
    checks++; if (ovf !== 8'd2) begin fails++; $display("FAIL ovf_count got %0d want 2", ovf); end
    checks++; if (ack_cnt - a0 != DEPTH + 3) begin fails++; $display("FAIL ovf_acks got %0d want %0d", ack_cnt - a0, DEPTH + 3); end
    checks++; if (rx_q.size() != rx_base) begin fails++; $display("FAIL ovf_stalled got %0d bytes want 0", rx_q.size() - rx_base); end
    tx_ready = 1'b1;
    wait_rx(14 * (DEPTH + 1));
    repeat (6) cyc();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== exp_q[i]) begin
        fails++; $display("FAIL ovf_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (rx_q.size() != rx_base + exp_q.size()) begin fails++; $display("FAIL ovf_total got %0d want %0d", rx_q.size() - rx_base, exp_q.size()); end
    checks++; if (lvl !== 3'd0) begin fails++; $display("FAIL ovf_drained got %0d want 0", lvl); end
  endtask
  task automatic test_stall();
    logic pv, pr;
    logic [7:0] pb;
    rx_base = rx_q.size();
    tx_ready = 1'b1; mode = 1;
    poly = 17'h10001; id0 = 17'h00055; id1 = 17'h000AA; ts = 24'h123456; da = 1'b1;
    cyc();
    da = 1'b0;
    for (int k = 0; k < 200 && rx_q.size() < rx_base + 14; k++) begin
      pv = tx_valid; pr = tx_ready; pb = tx_byte;
      cyc();
      if (pv && !pr) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_byte !== pb) begin fails++; $display("FAIL stall_hold got %b/%h want 1/%h", tx_valid, tx_byte, pb); end
      end
    end
    mode = 0; tx_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== ref1[i]) begin
        fails++; $display("FAIL stall_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, ref1[i]);
      end
    end
    repeat (4) cyc();
  endtask
  task automatic test_reset_mid();
    exp_q.delete(); rx_base = rx_q.size();
    tx_ready = 1'b0;
    send(17'($urandom), 17'($urandom), 17'($urandom), 1'b0);
    send(17'($urandom), 17'($urandom), 17'($urandom), 1'b0);
    tx_ready = 1'b1;
    wait_rx(7);
    reset = 1'b1;
    cyc();
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", tx_valid); end
    checks++; if (lvl !== 3'd0) begin fails++; $display("FAIL rst_mid_level got %0d want 0", lvl); end
    checks++; if (ovf !== 8'd0) begin fails++; $display("FAIL rst_mid_ovf got %0d want 0", ovf); end
    reset = 1'b0;
    repeat (3) cyc();
    checks++; if (tx_valid !== 1'b0 || rx_q.size() != rx_base + 7) begin fails++; $display("FAIL rst_mid_resume got valid %b bytes %0d want 0/7", tx_valid, rx_q.size() - rx_base); end
    rx_base = rx_q.size();
    send(17'($urandom), 17'($urandom), 17'($urandom), 1'b1);
    wait_rx(14);
    repeat (4) cyc();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== exp_q[i]) begin
        fails++; $display("FAIL rst_new_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, exp_q[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    exp_q.delete(); rx_base = rx_q.size();
    tx_ready = 1'b1;
    send(17'($urandom), 17'($urandom), 17'($urandom), 1'b1);
    send(17'($urandom), 17'($urandom), 17'($urandom), 1'b1);
    checks++; if (lvl !== 3'd1) begin fails++; $display("FAIL b2b_level got %0d want 1", lvl); end
    wait_rx(13);
    cyc();
    checks++; if (tx_valid !== 1'b0 || lvl !== 3'd1) begin fails++; $display("FAIL b2b_load got valid %b level %0d want 0/1", tx_valid, lvl); end
    poly = 17'($urandom); id0 = 17'($urandom); id1 = 17'($urandom); da = 1'b1;
    push_exp(poly, id0, id1, ts);
    cyc();
    checks++; if (lvl !== 3'd1 || ack !== 1'b1) begin fails++; $display("FAIL b2b_same_cycle got level %0d ack %b want 1/1", lvl, ack); end
    da = 1'b0;
    wait_rx(42);
    repeat (4) cyc();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, exp_q[i]);
      end
    end
  endtask
  task automatic test_random();
    exp_q.delete(); rx_base = rx_q.size();
    mode = 2;
    for (int k = 0; k < 8; k++) begin
      send(17'($urandom), 17'($urandom), 17'($urandom), 1'b1);
      repeat ($urandom_range(30, 45)) cyc();
    end
    wait_rx(14 * 8);
    mode = 0; tx_ready = 1'b1;
    repeat (4) cyc();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q.size() <= rx_base + i || rx_q[rx_base + i] !== exp_q[i]) begin
        fails++; $display("FAIL rnd_byte[%0d] got %h want %h", i, (rx_q.size() > rx_base + i) ? rx_q[rx_base + i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (ovf !== 8'd0) begin fails++; $display("FAIL rnd_ovf got %0d want 0", ovf); end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
